// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: qualifies PLL lock and drives PLL reset/relock; PLL_SUPERVISOR_RETRY_EN enables the acquisition timeout.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES      = 50,
  parameter int LOCK_STABLE_CYCLES    = 50000,
  parameter int RELOCK_TIMEOUT_CYCLES = 500000,
  parameter int CNT_W                 = 20
) (
  input  logic       CLKI,
  input  logic       RST,
  input  logic       LOCK,
  input  logic       clear_count,
  output logic       PLL_RST,
  output logic       sys_rst,
  output logic       locked,
  output logic [7:0] lock_loss_count,
  output logic [7:0] retry_count
);
`ifdef PLL_SUPERVISOR_RETRY_EN
  localparam logic RETRY_EN = 1'b1;
`else
  localparam logic RETRY_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(RELOCK_TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {PLL_RESET, WAIT_LOCK, STABLE, RUN} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic lock_m, lock_s, loss_inc, retry_inc;
  function automatic logic [7:0] bump(input logic [7:0] c, input logic inc, input logic clr);
    return clr ? {7'd0, inc} : (inc && c != 8'hff) ? c + 8'd1 : c;
  endfunction
  always_ff @(posedge CLKI or posedge RST)
    if (RST) {lock_m, lock_s} <= 2'b00;
    else     {lock_m, lock_s} <= {LOCK, lock_m};
  always_comb begin
    state_n   = state;
    loss_inc  = 1'b0;
    retry_inc = 1'b0;
    case (state)
      PLL_RESET: if (cnt == RST_LAST) state_n = WAIT_LOCK;
      WAIT_LOCK:
        if (lock_s) state_n = STABLE;
        else if (RETRY_EN && cnt == TO_LAST) begin
          state_n   = PLL_RESET;
          retry_inc = 1'b1;
        end
      STABLE:
        if (!lock_s) state_n = WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_n = RUN;
      RUN:
        if (!lock_s) begin
          state_n  = PLL_RESET;
          loss_inc = 1'b1;
        end
      default: state_n = PLL_RESET;
    endcase
    // counter restarts on every state entry; it idles at 0 in RUN and in an untimed WAIT_LOCK
    cnt_n = (state_n != state || state == RUN || (state == WAIT_LOCK && !RETRY_EN)) ? '0 : cnt + CNT_W'(1);
  end
  always_ff @(posedge CLKI or posedge RST)
    if (RST) begin
      state           <= PLL_RESET;
      cnt             <= '0;
      PLL_RST         <= 1'b1;
      sys_rst         <= 1'b1;
      locked          <= 1'b0;
      lock_loss_count <= 8'd0;
      retry_count     <= 8'd0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      PLL_RST         <= state_n == PLL_RESET;
      sys_rst         <= state_n != RUN;
      locked          <= state_n == RUN;
      lock_loss_count <= bump(lock_loss_count, loss_inc, clear_count);
      retry_count     <= bump(retry_count, retry_inc, clear_count);
    end
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: cycle-tagged scoreboard bench for pll_lock_supervisor.
module tb_pll_lock_supervisor;
`ifdef PLL_SUPERVISOR_RETRY_EN
  localparam logic RE = 1'b1;
`else
  localparam logic RE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, lock, clear_count;
  logic pll_rst, sys_rst, locked;
  logic [7:0] lock_loss_count, retry_count;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  typedef struct {
    int          cyc;
    int          tst;
    logic [18:0] v;
  } exp_t;
  exp_t q[$];
  exp_t e;
  pll_lock_supervisor #(
    .RST_PULSE_CYCLES(4), .LOCK_STABLE_CYCLES(16), .RELOCK_TIMEOUT_CYCLES(32), .CNT_W(8)
  ) dut (
    .CLKI(clk), .RST(rst), .LOCK(lock), .clear_count(clear_count),
    .PLL_RST(pll_rst), .sys_rst(sys_rst), .locked(locked),
    .lock_loss_count(lock_loss_count), .retry_count(retry_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_at(input int c, input int t, input logic p, input logic s, input logic l,
                           input logic [7:0] lc, input logic [7:0] rc);
    q.push_back('{c, t, {p, s, l, lc, rc}});
  endtask
  // outputs are compared on the falling edge of the cycle each expectation is tagged with
  always @(negedge clk)
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      total++;
      if (e.cyc != cyc || {pll_rst, sys_rst, locked, lock_loss_count, retry_count} !== e.v) begin
        bad++;
        $display("FAIL test%0d cyc=%0d due=%0d got pll/sys/lck/loss/retry=%b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                 e.tst, cyc, e.cyc, pll_rst, sys_rst, locked, lock_loss_count, retry_count,
                 e.v[18], e.v[17], e.v[16], e.v[15:8], e.v[7:0]);
      end
    end
  initial begin
    int b, c, d, f, g, n;
    rst = 1'b0;
    lock = 1'b0;
    clear_count = 1'b0;
    #2 rst = 1'b1;
    step(2);
    rst = 1'b0;
    b = cyc;
    for (int i = 0; i < 4; i++) expect_at(b + i, 1, 1, 1, 0, 0, 0);
    expect_at(b + 4, 1, 0, 1, 0, 0, 0);
    step(6);
    lock = 1'b1;
    b = cyc;
    expect_at(b + 18, 2, 0, 1, 0, 0, 0);
    expect_at(b + 19, 2, 0, 0, 1, 0, 0);
    step(21);
    lock = 1'b0;
    b = cyc;
    expect_at(b + 2, 4, 0, 0, 1, 0, 0);
    expect_at(b + 3, 4, 1, 1, 0, 1, 0);
    expect_at(b + 6, 4, 1, 1, 0, 1, 0);
    expect_at(b + 7, 4, 0, 1, 0, 1, 0);
    step(8);
    lock = 1'b1;
    c = cyc;
    expect_at(c + 12, 3, 0, 1, 0, 1, 0);
    step(10);
    lock = 1'b0;
    step(3);
    lock = 1'b1;
    d = cyc;
    expect_at(d + 18, 3, 0, 1, 0, 1, 0);
    expect_at(d + 19, 3, 0, 0, 1, 1, 0);
    step(20);
    n = 1;
    for (int i = 0; i < 300; i++) begin
      b = cyc;
      lock = 1'b0;
      n = (n < 255) ? n + 1 : 255;
      expect_at(b + 3, 4, 1, 1, 0, 8'(n), 0);
      expect_at(b + 27, 4, 0, 0, 1, 8'(n), 0);
      step(8);
      lock = 1'b1;
      step(20);
    end
    b = cyc;
    lock = 1'b0;
    step(2);
    clear_count = 1'b1;
    step(1);
    clear_count = 1'b0;
    expect_at(b + 3, 4, 1, 1, 0, 1, 0);
    expect_at(b + 38, 5, 0, 1, 0, 1, 0);
    expect_at(b + 39, 5, RE, 1, 0, 1, RE ? 8'd1 : 8'd0);
    expect_at(b + 42, 5, RE, 1, 0, 1, RE ? 8'd1 : 8'd0);
    expect_at(b + 43, 5, 0, 1, 0, 1, RE ? 8'd1 : 8'd0);
    expect_at(b + 75, 5, RE, 1, 0, 1, RE ? 8'd2 : 8'd0);
    step(77);
    clear_count = 1'b1;
    step(1);
    clear_count = 1'b0;
    expect_at(b + 81, 5, 0, 1, 0, 0, 0);
    lock = 1'b1;
    step(20);
    expect_at(cyc, 6, 0, 0, 1, 0, 0);
    f = cyc;
    lock = 1'b0;
    expect_at(f + 3, 6, 1, 1, 0, 1, 0);
    step(8);
    lock = 1'b1;
    expect_at(f + 27, 6, 0, 0, 1, 1, 0);
    step(20);
    g = cyc;
    rst = 1'b1;
    #1;
    expect_at(g, 6, 1, 1, 0, 0, 0);
    step(1);
    expect_at(g + 1, 6, 1, 1, 0, 0, 0);
    rst = 1'b0;
    expect_at(g + 5, 6, 0, 1, 0, 0, 0);
    expect_at(g + 6, 6, 0, 1, 0, 0, 0);
    step(6);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
